cassette_recorder: RTL
======================

Name: cassette_recorder

Overview:
- Recording counterpart of the cassette player: decodes the console's FSK tape-output signal back into bytes and writes them, as a CAS image, into the SDRAM cassette region.
- Runs on the 21.3 MHz cassette clock. Address output is 21-bit; the top level prefixes it with 2'b11 exactly as for cassette playback.
- Shares the CPU-refresh SDRAM slot with the player; only one of the two is active at a time.

Parameters:
- TICK_DIV, 21, clk cycles per 1 µs tick.
- PERIOD_MIN, 200, shortest legal full period in µs; shorter periods are glitches and ignored.
- PERIOD_SPLIT, 625, period in µs below which a period is short (2400 Hz), otherwise long (1200 Hz).
- PERIOD_MAX, 1250, period or silence in µs above which a gap is declared.
- LEADER_MIN, 16, consecutive '1' bits required before a start bit is accepted.

Ports:
- clk  in  1  cassette clock (21.3 MHz).
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous; rewinds the write pointer and clears the flags.
- motor_n  in  1  console motor control, active low; the recorder runs only while it is 0.
- tape_out  in  1  console tape-write level, asynchronous to clk.
- sdram_addr  out  21  write byte address.
- sdram_data  out  8  write byte.
- sdram_wr  out  1  write request, held until acknowledged.
- sdram_available  in  1  SDRAM slot free (CPU refresh cycle).
- sdram_ready  in  1  one-cycle acknowledge of a write.
- length  out  21  number of bytes written so far.
- status  out  3  0 idle, 1 sync/leader, 2 data, 3 SDRAM full.
- overflow  out  1  sticky; a byte was dropped.

Behaviour:
- Reset values: every output is 0; FSM is in IDLE; write pointer is 0; holding register is empty.
- Input sync:
  - tape_out and motor_n each pass through a 2-FF synchroniser.
  - A rising edge is detected on the synchronised tape_out.
- Tick prescaler counts 0..TICK_DIV-1; a µs tick fires on wrap.
- Period counter:
  - 11 bits, counts µs, saturates at PERIOD_MAX+1.
  - On a rising edge:
    - period < PERIOD_MIN: ignored; the counter is not reset.
    - otherwise the counter value is classified short/long and the counter resets to 0.
  - Counter reaching PERIOD_MAX+1 raises one gap event.
- Bit decode:
  - One long period produces bit 0.
  - Two consecutive short periods produce bit 1. A half flag holds the first short.
  - Long period arriving while the half flag is set: the half flag is cleared, no bit is produced, and the FSM goes to SYNC.
  - A gap also clears the half flag.
- FSM:
  - IDLE: entered from any state when motor_n=1 (no byte is committed). Leaves to SYNC when motor_n=0.
  - SYNC: counts consecutive 1s (5-bit counter, saturating).
    - Bit 0 with count ≥ LEADER_MIN goes to DATA; that 0 is the start bit.
    - Bit 0 with count < LEADER_MIN resets the count.
  - DATA: shifts in 8 bits, MSB first. On the 8th bit the byte is pushed to the holding register and the FSM goes to WAIT_START.
  - WAIT_START: 1s are ignored; a 0 goes to DATA.
  - Gap in DATA or WAIT_START: back to SYNC and the partial byte is discarded.
- Holding register and write:
  - Depth is one byte.
  - Push while the register is still full: byte dropped and overflow set.
  - Register full and sdram_available=1: assert sdram_wr with sdram_addr = pointer and sdram_data = byte. These stay stable until sdram_ready.
  - On the cycle sdram_ready=1: sdram_wr drops, the register empties, and pointer and length increment.
  - A request, once raised, is held even if sdram_available falls.
- Full condition:
  - When the pointer reaches 2^21-1, status becomes 3.
  - Further pushes are dropped and set overflow; the pointer never wraps.
- clear:
  - Pointer, length and overflow go to 0.
  - The FSM goes to SYNC if motor_n=0, else IDLE.
  - If sdram_wr is pending it is dropped immediately and the register empties.
- Simultaneous clear and push: clear wins and the byte is discarded.

Test Plan:
1. Reset → all outputs 0. With motor_n=1 and a 2400 Hz tone: status stays 0 and sdram_wr never rises.
2. motor_n=0; 20 leader '1' bits (417 µs periods); start 0 (833 µs); byte 0xA5; sdram_available=1; ready 3 cycles after wr → one write of addr 0, data 0xA5; length=1; status=2 during the byte.
3. Leader of only 10 '1's then start bit and 0x55 → no write; status remains 1.
4. Two back-to-back bytes 0x7F, 0x00 with sdram_available=0 throughout → first is held, second is dropped; overflow=1. Then raise available → a single write of 0x7F.
5. 1500 µs silence mid-byte after 4 bits → FSM returns to SYNC; no write; a fresh leader plus 0x3C then writes 0x3C at the next address.
6. Assert clear while sdram_wr is pending at length=5 → sdram_wr drops the next cycle; length=0; overflow=0; the next byte is written at addr 0.

Source files
------------

// File: rtl/cassette_recorder_if.sv
// SDRAM write port used by the cassette recorder.
// master: recorder side, drives the byte address, data and write request.
// slave : memory arbiter side, drives the slot-available and acknowledge strobes.
interface cassette_recorder_if;
  logic [20:0] sdram_addr;
  logic [7:0]  sdram_data;
  logic        sdram_wr;
  logic        sdram_available;
  logic        sdram_ready;

  modport master (
    output sdram_addr,
    output sdram_data,
    output sdram_wr,
    input  sdram_available,
    input  sdram_ready
  );

  modport slave (
    input  sdram_addr,
    input  sdram_data,
    input  sdram_wr,
    output sdram_available,
    output sdram_ready
  );
endinterface

// File: rtl/cassette_recorder.sv
// Cassette recorder: decodes the console FSK tape-output signal into bytes and writes them
// into the SDRAM cassette region as a CAS image.
// Ports:
//   clk, reset     cassette clock, asynchronous active-high reset
//   clear          synchronous rewind of write pointer and flags
//   motor_n        console motor control, recorder runs while 0 (asynchronous)
//   tape_out       console tape-write level (asynchronous)
//   sdram          write port (addr, data, wr out; available, ready in)
//   length         bytes written so far
//   status         0 idle, 1 sync/leader, 2 data, 3 SDRAM full
//   overflow       sticky, a decoded byte was dropped
module cassette_recorder #(
  parameter int unsigned TICK_DIV     = 21,
  parameter int unsigned PERIOD_MIN   = 200,
  parameter int unsigned PERIOD_SPLIT = 625,
  parameter int unsigned PERIOD_MAX   = 1250,
  parameter int unsigned LEADER_MIN   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                motor_n,
  input  logic                tape_out,
  cassette_recorder_if.master sdram,
  output logic [20:0]         length,
  output logic [2:0]          status,
  output logic                overflow
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [10:0] PerMin   = 11'(PERIOD_MIN);
  localparam logic [10:0] PerSplit = 11'(PERIOD_SPLIT);
  localparam logic [10:0] PerMax   = 11'(PERIOD_MAX);
  localparam logic [10:0] PerSat   = 11'(PERIOD_MAX + 1);
  localparam logic [4:0]  LeadMin  = 5'(LEADER_MIN);
  localparam logic [20:0] PtrLast  = '1;

  typedef enum logic [1:0] {StIdle, StSync, StData, StWaitStart} state_e;

  logic [1:0]       tape_sync_q, tape_sync_d;
  logic             tape_prev_q, tape_prev_d;
  logic [1:0]       motor_sync_q, motor_sync_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [10:0]      per_q, per_d;
  logic             half_q, half_d;
  state_e           state_q, state_d;
  logic [4:0]       lead_q, lead_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             wr_q, wr_d;
  logic [20:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [20:0]      ptr_q, ptr_d;
  logic [2:0]       status_q, status_d;
  logic             overflow_q, overflow_d;

  logic       motor_off, rise, tick, valid_edge, is_short, gap;
  logic       bit_valid, bit_val, desync, push;
  logic [7:0] push_byte;

  always_comb begin
    tape_sync_d  = {tape_sync_q[0], tape_out};
    motor_sync_d = {motor_sync_q[0], motor_n};
    tape_prev_d  = tape_sync_q[1];
    motor_off    = motor_sync_q[1];
    rise         = tape_sync_q[1] & ~tape_prev_q;

    // Microsecond tick prescaler.
    tick   = (tick_q == TickLast);
    tick_d = tick ? '0 : tick_q + TickW'(1);

    // Period measurement; glitch edges leave the counter running.
    valid_edge = rise && (per_q >= PerMin);
    is_short   = per_q < PerSplit;
    gap        = tick && (per_q == PerMax) && !valid_edge;
    per_d      = per_q;
    if (valid_edge) begin
      per_d = '0;
    end else if (tick && (per_q != PerSat)) begin
      per_d = per_q + 11'd1;
    end

    // Bit decode: one long period is a 0, two shorts are a 1.
    bit_valid = 1'b0;
    bit_val   = 1'b0;
    desync    = 1'b0;
    half_d    = half_q;
    if (gap) begin
      half_d = 1'b0;
    end else if (valid_edge) begin
      if (is_short) begin
        if (half_q) begin
          bit_valid = 1'b1;
          bit_val   = 1'b1;
          half_d    = 1'b0;
        end else begin
          half_d = 1'b1;
        end
      end else if (half_q) begin
        // Long after a lone short means we lost bit alignment.
        half_d = 1'b0;
        desync = 1'b1;
      end else begin
        bit_valid = 1'b1;
      end
    end

    // Framing FSM.
    state_d   = state_q;
    lead_d    = lead_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    push_byte = {shift_q[6:0], bit_val};
    if (motor_off) begin
      state_d = StIdle;
    end else if (clear || (state_q == StIdle)) begin
      state_d = StSync;
      lead_d  = '0;
    end else if (desync || (gap && (state_q != StSync))) begin
      state_d = StSync;
      lead_d  = '0;
    end else if (bit_valid) begin
      case (state_q)
        StSync: begin
          if (bit_val) begin
            if (lead_q != 5'h1f) lead_d = lead_q + 5'd1;
          end else if (lead_q >= LeadMin) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            lead_d = '0;
          end
        end
        StData: begin
          shift_d   = push_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            push    = 1'b1;
            state_d = StWaitStart;
          end
        end
        StWaitStart: begin
          if (!bit_val) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end

    // One-byte holding register and SDRAM write handshake.
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    ptr_d       = ptr_q;
    overflow_d  = overflow_q;
    if (clear) begin
      ptr_d       = '0;
      overflow_d  = 1'b0;
      wr_d        = 1'b0;
      hold_full_d = 1'b0;
    end else begin
      if (wr_q && sdram.sdram_ready) begin
        wr_d        = 1'b0;
        hold_full_d = 1'b0;
        if (ptr_q != PtrLast) ptr_d = ptr_q + 21'd1;
      end else if (hold_full_q && !wr_q && sdram.sdram_available) begin
        wr_d   = 1'b1;
        addr_d = ptr_q;
        data_d = hold_data_q;
      end
      if (push) begin
        if (hold_full_q || (ptr_q == PtrLast)) begin
          overflow_d = 1'b1;
        end else begin
          hold_full_d = 1'b1;
          hold_data_d = push_byte;
        end
      end
    end

    if (ptr_d == PtrLast) begin
      status_d = 3'd3;
    end else begin
      case (state_d)
        StSync:             status_d = 3'd1;
        StData, StWaitStart: status_d = 3'd2;
        default:            status_d = 3'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tape_sync_q  <= 2'b00;
      tape_prev_q  <= 1'b0;
      motor_sync_q <= 2'b11;
      tick_q       <= '0;
      per_q        <= '0;
      half_q       <= 1'b0;
      state_q      <= StIdle;
      lead_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_full_q  <= 1'b0;
      hold_data_q  <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      ptr_q        <= '0;
      status_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      tape_sync_q  <= tape_sync_d;
      tape_prev_q  <= tape_prev_d;
      motor_sync_q <= motor_sync_d;
      tick_q       <= tick_d;
      per_q        <= per_d;
      half_q       <= half_d;
      state_q      <= state_d;
      lead_q       <= lead_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_full_q  <= hold_full_d;
      hold_data_q  <= hold_data_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ptr_q        <= ptr_d;
      status_q     <= status_d;
      overflow_q   <= overflow_d;
    end
  end

  assign sdram.sdram_addr = addr_q;
  assign sdram.sdram_data = data_q;
  assign sdram.sdram_wr   = wr_q;
  assign length           = ptr_q;
  assign status           = status_q;
  assign overflow         = overflow_q;

endmodule
